uart_port_responder: RTL

Device-side model of the board's external serial-port chip: the responder to the memory controller's `rdn`/`wrn` strobes and the source of its `data_ready`/`tbre`/`tsre` status. Bytes written by the CPU are serialized 8N1 on `txd`; bytes arriving on `rxd` are deserialized into a receive buffer and presented on the data bus while `rdn` is low. Used both as a synthesizable UART peripheral and as the bench-side partner for the memory controller.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_port_responder_if.sv | 32 +++
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_port_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the serial-port responder.
// Holds the TX/RX state encodings, the data-bit index width and the
// frame length (start + 8 data + stop).
package uart_pkg;

  localparam int BIT_IDX_W  = 3;
  localparam int FRAME_BITS = 10;

  // Index of the last data bit in a frame (frame minus start and stop).
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(FRAME_BITS - 3);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_port_responder_if.sv
// Bus between the memory controller (master) and the serial-port
// responder (slave).
//   rdn, wrn    : active-low read / write strobes from the controller
//   data_in     : byte written by the controller
//   data_out    : receive buffer, valid while data_oe is high
//   data_oe     : bus drive enable (high while rdn is low)
//   data_ready  : unread byte in the receive buffer
//   tbre, tsre  : transmit holding / shift register empty
//   frame_err   : sticky bad-stop-bit flag, cleared by a read
//   overrun     : sticky lost-byte flag, cleared by a read
interface uart_port_responder_if;
  logic       rdn;
  logic       wrn;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       data_ready;
  logic       tbre;
  logic       tsre;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rdn, wrn, data_in,
    input  data_out, data_oe, data_ready, tbre, tsre, frame_err, overrun
  );

  modport slave (
    input  rdn, wrn, data_in,
    output data_out, data_oe, data_ready, tbre, tsre, frame_err, overrun
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Serial bit-period timer.
//   CLK, RST : clock, asynchronous active-low reset
//   run      : count while high, hold while low
//   start    : restart the period from zero (wins over run)
//   half     : last cycle of the first half of the period
//   tick     : last cycle of the period; the counter wraps after it
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  input  logic start,
  output logic half,
  output logic tick
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

  assign half = run && (cnt == CNT_MID);
  assign tick = run && (cnt == CNT_LAST);
endmodule

// File: rtl/uart_port_responder.sv
// Device-side model of the external serial-port chip. Bytes written over
// the bus are sent 8N1 on txd; bytes received on rxd land in the receive
// buffer, which is presented on the bus while rdn is low.
//   CLK, RST : clock, asynchronous active-low reset
//   bus      : controller-facing strobes, data and status (slave side)
//   rxd      : serial input, idle high, asynchronous to CLK
//   txd      : serial output, idle high
module uart_port_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_port_responder_if.slave  bus,
  input  logic                  rxd,
  output logic                  txd
);
  logic rdn_p1, wrn_p1;
  logic rxd_p1, rxd_p2, rxd_p3;

  tx_state_t            tx_state;
  rx_state_t            rx_state;
  logic [BIT_IDX_W-1:0] tx_idx, tx_idx_nxt, rx_idx;
  logic [7:0]           thr, tx_shift, rx_shift, rbr;
  logic                 tbre_q, tsre_q, dr_q, fe_q, ov_q;

  logic tx_tick, tx_half_unused, rx_tick, rx_half;
  logic wr_evt, wr_acc, rd_end, tx_load;
  logic rx_fall, rx_tmr_start, rx_load, rx_ferr;

  // Stage p1: strobe registers and rxd synchronizer (p1/p2), p3 for edge detect
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdn_p1 <= 1'b1;
      wrn_p1 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
      rxd_p3 <= 1'b1;
    end else begin
      rdn_p1 <= bus.rdn;
      wrn_p1 <= bus.wrn;
      rxd_p1 <= rxd;
      rxd_p2 <= rxd_p1;
      rxd_p3 <= rxd_p2;
    end
  end

  assign wr_evt  = wrn_p1 & ~bus.wrn;
  assign rd_end  = ~rdn_p1 & bus.rdn;
  // THR empties into the shifter whenever the line can take a new frame.
  assign tx_load = ~tbre_q & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_tick));
  // A write landing on the same edge as that move still finds room.
  assign wr_acc  = wr_evt & (tbre_q | tx_load);
  assign tx_idx_nxt = tx_idx + BIT_IDX_W'(1);

  assign rx_fall      = rxd_p3 & ~rxd_p2;
  // Timer restarts on the start edge and again at mid-start, so every
  // later tick falls in the middle of a bit.
  assign rx_tmr_start = ((rx_state == RX_IDLE) & rx_fall) |
                        ((rx_state == RX_START) & rx_half & ~rxd_p2);
  assign rx_load      = (rx_state == RX_STOP) & rx_tick & rxd_p2;
  assign rx_ferr      = (rx_state == RX_STOP) & rx_tick & ~rxd_p2;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .CLK   (CLK),
    .RST   (RST),
    .run   (tx_state != TX_IDLE),
    .start (tx_load),
    .half  (tx_half_unused),
    .tick  (tx_tick)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .CLK   (CLK),
    .RST   (RST),
    .run   (rx_state != RX_IDLE),
    .start (rx_tmr_start),
    .half  (rx_half),
    .tick  (rx_tick)
  );

  // Stage p2: transmit FSM with registered txd
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state <= TX_IDLE;
      tx_idx   <= '0;
      txd      <= 1'b1;
      tbre_q   <= 1'b1;
      tsre_q   <= 1'b1;
    end else begin
      if (wr_acc) begin
        tbre_q <= 1'b0;
      end else if (tx_load) begin
        tbre_q <= 1'b1;
      end
      case (tx_state)
        TX_IDLE: begin
          if (tx_load) begin
            tsre_q   <= 1'b0;
            txd      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_idx   <= '0;
            txd      <= tx_shift[0];
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_idx == LAST_BIT) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_idx <= tx_idx_nxt;
              txd    <= tx_shift[tx_idx_nxt];
            end
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            if (tx_load) begin
              txd      <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tsre_q   <= 1'b1;
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      thr <= bus.data_in;
    end
    if (tx_load) begin
      tx_shift <= thr;
    end
    if ((rx_state == RX_DATA) && rx_tick) begin
      rx_shift <= {rxd_p2, rx_shift[7:1]};
    end
  end

  // Stage p4: receive FSM, receive buffer and sticky status
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_state <= RX_IDLE;
      rx_idx   <= '0;
      rbr      <= '0;
      dr_q     <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      // A byte arriving on the read-end edge survives the read.
      if (rx_load) begin
        rbr  <= rx_shift;
        dr_q <= 1'b1;
        ov_q <= rd_end ? 1'b0 : (ov_q | dr_q);
        if (rd_end) begin
          fe_q <= 1'b0;
        end
      end else if (rx_ferr) begin
        fe_q <= 1'b1;
        if (rd_end) begin
          dr_q <= 1'b0;
          ov_q <= 1'b0;
        end
      end else if (rd_end) begin
        dr_q <= 1'b0;
        fe_q <= 1'b0;
        ov_q <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_half) begin
            if (rxd_p2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_idx   <= '0;
              rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_idx <= rx_idx + BIT_IDX_W'(1);
            if (rx_idx == LAST_BIT) begin
              rx_state <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.data_out   = rbr;
  assign bus.data_oe    = ~bus.rdn;
  assign bus.data_ready = dr_q;
  assign bus.tbre       = tbre_q;
  assign bus.tsre       = tsre_q;
  assign bus.frame_err  = fe_q;
  assign bus.overrun    = ov_q;
endmodule
